// File: rtl/fetch_unit.sv
// Instruction fetch: fpc-driven imem requests, 2-deep {pc,instr} buffer, IF output register; 1-cycle ack-to-IF latency (bypass when buffer empty).
// Backpressure: AnyStall freezes the IF register while fetch fills the buffer, then parks in HOLD with ImemReq low.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        AnyStall,
  input  logic        Jump_IDM1,
  input  logic [25:0] JumpTgt_IDM1,
  input  logic        BrTaken_EX,
  input  logic [31:0] BrTgt_EX,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic [31:0] Pc_IF,
  output logic [31:0] FetchData_IF,
  output logic        FetchValid_IF
);

  typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  state_t      state, state_nxt;
  logic        run;
  logic [31:0] fpc, fpc_nxt, drain_addr;
  ent_t        fifo_q [2];
  logic [1:0]  cnt, cnt_nxt, wr_idx;
  logic [31:0] pc_if_plus4, tgt;
  logic        jmp_redir, redir, acc, bypass, push, pop;

  // run keeps ImemReq low until the first edge after reset release
  assign ImemReq     = run && (state != HOLD);
  assign ImemAddr    = (state == DRAIN) ? drain_addr : fpc;
  assign acc         = ImemReq && ImemAck;
  assign pc_if_plus4 = Pc_IF + 32'd4;
  assign jmp_redir   = Jump_IDM1 && FetchValid_IF && !AnyStall;
  assign redir       = BrTaken_EX || jmp_redir;
  assign tgt         = BrTaken_EX ? BrTgt_EX : {pc_if_plus4[31:28], JumpTgt_IDM1, 2'b00};
  assign pop         = !redir && !AnyStall && (cnt != 2'd0);
  assign bypass      = !redir && !AnyStall && acc && (state == FETCH) && (cnt == 2'd0);
  assign push        = !redir && acc && (state == FETCH) && !bypass;
  assign wr_idx      = cnt - {1'b0, pop};

  always_comb begin
    state_nxt = state;
    fpc_nxt   = fpc;
    cnt_nxt   = redir ? 2'd0 : (cnt + {1'b0, push} - {1'b0, pop});
    if (redir) begin
      fpc_nxt = tgt;
    end else if (acc && (state == FETCH)) begin
      fpc_nxt = fpc + 32'd4;
    end
    case (state)
      FETCH: begin
        if (redir) begin
          if (ImemReq && !ImemAck) state_nxt = DRAIN;
        end else if (push && (cnt_nxt == 2'd2)) begin
          state_nxt = HOLD;
        end
      end
      // an ack here completes the abandoned request; its data is discarded
      DRAIN: if (acc) state_nxt = FETCH;
      HOLD:  if (cnt_nxt != 2'd2) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH;
      run        <= 1'b0;
      fpc        <= RESET_PC;
      drain_addr <= RESET_PC;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      fpc   <= fpc_nxt;
      if (state == FETCH) drain_addr <= fpc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= 2'd0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (pop)  fifo_q[0] <= fifo_q[1];
      if (push) fifo_q[wr_idx[0]] <= '{pc: fpc, instr: ImemData};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Pc_IF         <= RESET_PC;
      FetchData_IF  <= NOP_WORD;
      FetchValid_IF <= 1'b0;
    end else if (redir) begin
      FetchData_IF  <= NOP_WORD;
      FetchValid_IF <= 1'b0;
    end else if (!AnyStall) begin
      if (pop) begin
        Pc_IF         <= fifo_q[0].pc;
        FetchData_IF  <= fifo_q[0].instr;
        FetchValid_IF <= 1'b1;
      end else if (bypass) begin
        Pc_IF         <= fpc;
        FetchData_IF  <= ImemData;
        FetchValid_IF <= 1'b1;
      end else begin
        FetchData_IF  <= NOP_WORD;
        FetchValid_IF <= 1'b0;
      end
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (!reset_n) !(push && !pop && (cnt == 2'd2)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n) !(pop && (cnt == 2'd0)));

endmodule
